// File: rtl/bob_retire_pkg.sv
// Shared branch-predictor constants, BOB head entry layout and retire FSM encoding.
package bob_retire_pkg;

    localparam int BOB_PCW    = 64;
    localparam int BHTW       = 10;
    localparam int BHRW       = 12;
    localparam int RASW       = 4;
    localparam int INSN_BYTES = 4;

    // 93-bit checkpoint written by the fetch side, popped here at retire.
    typedef struct packed {
        logic [BOB_PCW-1:0] brpc;
        logic               brdir;
        logic               chwe;
        logic               chbrdir;
        logic [BHTW-1:0]    bht;
        logic [BHRW-1:0]    bhr;
        logic [RASW-1:0]    rasptr;
    } bob_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/bob_retire_sat_counter.sv
// Saturating up-counter for performance statistics.
// Latency: count reflects an increment one cycle after inc; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bob_retire.sv
// Retire-side BOB consumer: pops the head checkpoint, updates predictor tables, recovers on mispredict.
// Latency: pop is combinational; updates/recovery registered, 1 cycle after accept.
// Backpressure: none; retires are ignored (not popped) while draining after a flush.
module bob_retire
    import bob_retire_pkg::*;
#(
    parameter int PCW          = BOB_PCW,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNTW         = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             brcond_vld_rt_i,
    input  logic             brcond_taken_rt_i,
    input  logic [PCW-1:0]   brcond_tgt_rt_i,
    input  logic             bob_valid_i,
    input  logic [PCW-1:0]   bob_brpc_i,
    input  logic             bob_brdir_i,
    input  logic             bob_chwe_i,
    input  logic             bob_chbrdir_i,
    input  logic [BHTW-1:0]  bob_bht_i,
    input  logic [BHRW-1:0]  bob_bhr_i,
    input  logic [RASW-1:0]  bob_rasptr_i,
    output logic             bob_re_o,
    output logic             lht_we_o,
    output logic [BHTW-1:0]  lht_idx_o,
    output logic [BHTW-1:0]  lht_wdata_o,
    output logic             lpht_we_o,
    output logic [BHTW-1:0]  lpht_idx_o,
    output logic             lpht_taken_o,
    output logic             gpht_we_o,
    output logic [BHRW-1:0]  gpht_idx_o,
    output logic             gpht_taken_o,
    output logic             cpht_we_o,
    output logic [BHRW-1:0]  cpht_idx_o,
    output logic             cpht_dir_o,
    output logic             recov_vld_o,
    output logic [PCW-1:0]   recov_pc_o,
    output logic [BHRW-1:0]  recov_bhr_o,
    output logic [RASW-1:0]  recov_rasptr_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNTW-1:0]  br_cnt_o,
    output logic [CNTW-1:0]  mis_cnt_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t      state;
    logic [DW-1:0] drain_cnt;
    bob_entry_t  head;
    logic        accept;
    logic        emit;
    logic        mis;
    logic        taken;

    assign head = '{brpc:    bob_brpc_i,
                    brdir:   bob_brdir_i,
                    chwe:    bob_chwe_i,
                    chbrdir: bob_chbrdir_i,
                    bht:     bob_bht_i,
                    bhr:     bob_bhr_i,
                    rasptr:  bob_rasptr_i};

    assign taken    = brcond_taken_rt_i;
    assign accept   = brcond_vld_rt_i & bob_valid_i & (state != ST_DRAIN);
    assign bob_re_o = accept;
    // A younger branch popped while an older mispredict is being emitted is on the wrong path.
    assign emit     = accept & ~recov_vld_o;
    assign mis      = taken != head.brdir;

    always_ff @(posedge clock) begin
        if (reset) begin
            lht_we_o       <= 1'b0;
            lht_idx_o      <= '0;
            lht_wdata_o    <= '0;
            lpht_we_o      <= 1'b0;
            lpht_idx_o     <= '0;
            lpht_taken_o   <= 1'b0;
            gpht_we_o      <= 1'b0;
            gpht_idx_o     <= '0;
            gpht_taken_o   <= 1'b0;
            cpht_we_o      <= 1'b0;
            cpht_idx_o     <= '0;
            cpht_dir_o     <= 1'b0;
            recov_vld_o    <= 1'b0;
            recov_pc_o     <= '0;
            recov_bhr_o    <= '0;
            recov_rasptr_o <= '0;
            flush_o        <= 1'b0;
        end else begin
            lht_we_o    <= emit;
            lpht_we_o   <= emit;
            gpht_we_o   <= emit;
            cpht_we_o   <= emit & head.chwe;
            recov_vld_o <= emit & mis;
            flush_o     <= emit & mis;
            if (emit) begin
                lht_idx_o      <= head.brpc[BHTW+1:2];
                lht_wdata_o    <= {head.bht[BHTW-2:0], taken};
                lpht_idx_o     <= head.bht;
                lpht_taken_o   <= taken;
                gpht_idx_o     <= head.bhr;
                gpht_taken_o   <= taken;
                cpht_idx_o     <= head.bhr;
                cpht_dir_o     <= head.chbrdir;
                recov_pc_o     <= taken ? brcond_tgt_rt_i : head.brpc + PCW'(INSN_BYTES);
                recov_bhr_o    <= {head.bhr[BHRW-2:0], taken};
                recov_rasptr_o <= head.rasptr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (recov_vld_o) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                        busy_o    <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_o <= 1'b0;
        end else if (brcond_vld_rt_i && !bob_valid_i && state != ST_DRAIN) begin
            err_o <= 1'b1;
        end
    end

    sat_counter #(.W(CNTW)) u_br_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (emit),
        .count (br_cnt_o)
    );

    sat_counter #(.W(CNTW)) u_mis_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (emit & mis),
        .count (mis_cnt_o)
    );

endmodule

// File: tb/tb_bob_retire.sv
// Directed plus randomized bench for bob_retire against a cycle-level reference model.
module tb_bob_retire;
    import bob_retire_pkg::*;

    localparam int DRAIN = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         brcond_vld_rt_i, brcond_taken_rt_i;
    logic [63:0]  brcond_tgt_rt_i;
    logic         bob_valid_i, bob_brdir_i, bob_chwe_i, bob_chbrdir_i;
    logic [63:0]  bob_brpc_i;
    logic [9:0]   bob_bht_i;
    logic [11:0]  bob_bhr_i;
    logic [3:0]   bob_rasptr_i;
    logic         bob_re_o, lht_we_o, lpht_we_o, lpht_taken_o, gpht_we_o, gpht_taken_o;
    logic         cpht_we_o, cpht_dir_o, recov_vld_o, flush_o, busy_o, err_o;
    logic [9:0]   lht_idx_o, lht_wdata_o, lpht_idx_o;
    logic [11:0]  gpht_idx_o, cpht_idx_o, recov_bhr_o;
    logic [63:0]  recov_pc_o;
    logic [3:0]   recov_rasptr_o;
    logic [31:0]  br_cnt_o, mis_cnt_o;

    int checks = 0;
    int failures = 0;

    // Reference model: what the DUT must present in the current cycle.
    int              m_drain = 0;
    bit              m_err = 0, m_pend = 0, m_pmis = 0, m_pchwe = 0, m_t = 0, m_cdir = 0;
    longint unsigned m_br = 0, m_mis = 0;
    logic [9:0]      m_lht_idx, m_lht_wdata, m_lpht_idx;
    logic [11:0]     m_bhr, m_rbhr;
    logic [63:0]     m_rpc;
    logic [3:0]      m_rras;

    always #5 clock = ~clock;

    bob_retire dut (
        .clock(clock), .reset(reset),
        .brcond_vld_rt_i(brcond_vld_rt_i), .brcond_taken_rt_i(brcond_taken_rt_i),
        .brcond_tgt_rt_i(brcond_tgt_rt_i), .bob_valid_i(bob_valid_i),
        .bob_brpc_i(bob_brpc_i), .bob_brdir_i(bob_brdir_i), .bob_chwe_i(bob_chwe_i),
        .bob_chbrdir_i(bob_chbrdir_i), .bob_bht_i(bob_bht_i), .bob_bhr_i(bob_bhr_i),
        .bob_rasptr_i(bob_rasptr_i), .bob_re_o(bob_re_o),
        .lht_we_o(lht_we_o), .lht_idx_o(lht_idx_o), .lht_wdata_o(lht_wdata_o),
        .lpht_we_o(lpht_we_o), .lpht_idx_o(lpht_idx_o), .lpht_taken_o(lpht_taken_o),
        .gpht_we_o(gpht_we_o), .gpht_idx_o(gpht_idx_o), .gpht_taken_o(gpht_taken_o),
        .cpht_we_o(cpht_we_o), .cpht_idx_o(cpht_idx_o), .cpht_dir_o(cpht_dir_o),
        .recov_vld_o(recov_vld_o), .recov_pc_o(recov_pc_o), .recov_bhr_o(recov_bhr_o),
        .recov_rasptr_o(recov_rasptr_o), .flush_o(flush_o), .busy_o(busy_o),
        .err_o(err_o), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit v, input bit bv, input bit t,
                         input logic [63:0] pc, input logic [63:0] tgt, input bit dir,
                         input bit cwe, input bit cdir, input logic [9:0] bht,
                         input logic [11:0] bhr, input logic [3:0] ras);
        reset = rst; brcond_vld_rt_i = v; bob_valid_i = bv; brcond_taken_rt_i = t;
        bob_brpc_i = pc; brcond_tgt_rt_i = tgt; bob_brdir_i = dir; bob_chwe_i = cwe;
        bob_chbrdir_i = cdir; bob_bht_i = bht; bob_bhr_i = bhr; bob_rasptr_i = ras;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 0, 10'h0, 12'h0, 4'h0);
    endtask

    task automatic check_outputs();
        chk("lht_we", lht_we_o, m_pend);
        chk("lpht_we", lpht_we_o, m_pend);
        chk("gpht_we", gpht_we_o, m_pend);
        chk("cpht_we", cpht_we_o, m_pend & m_pchwe);
        chk("recov_vld", recov_vld_o, m_pend & m_pmis);
        chk("flush", flush_o, m_pend & m_pmis);
        chk("busy", busy_o, m_drain > 0);
        chk("err", err_o, m_err);
        chk("br_cnt", br_cnt_o, m_br);
        chk("mis_cnt", mis_cnt_o, m_mis);
        if (m_pend) begin
            chk("lht_idx", lht_idx_o, m_lht_idx);
            chk("lht_wdata", lht_wdata_o, m_lht_wdata);
            chk("lpht_idx", lpht_idx_o, m_lpht_idx);
            chk("lpht_taken", lpht_taken_o, m_t);
            chk("gpht_idx", gpht_idx_o, m_bhr);
            chk("gpht_taken", gpht_taken_o, m_t);
            if (m_pchwe) begin
                chk("cpht_idx", cpht_idx_o, m_bhr);
                chk("cpht_dir", cpht_dir_o, m_cdir);
            end
            if (m_pmis) begin
                chk("recov_pc", recov_pc_o, m_rpc);
                chk("recov_bhr", recov_bhr_o, m_rbhr);
                chk("recov_rasptr", recov_rasptr_o, m_rras);
            end
        end
    endtask

    // Check the current cycle at the falling edge, advance the model, land #1 after the next rising edge.
    task automatic step();
        bit acc, out_mis;
        @(negedge clock);
        check_outputs();
        acc = brcond_vld_rt_i & bob_valid_i & (m_drain == 0);
        if (reset) begin
            m_drain = 0; m_err = 0; m_pend = 0; m_pmis = 0; m_br = 0; m_mis = 0;
        end else begin
            chk("bob_re", bob_re_o, acc);
            out_mis = m_pend & m_pmis;
            if (brcond_vld_rt_i && !bob_valid_i && m_drain == 0) m_err = 1;
            if (m_drain > 0) m_drain--;
            if (out_mis) m_drain = DRAIN;
            m_pend = acc & ~out_mis;
            if (m_pend) begin
                m_t         = brcond_taken_rt_i;
                m_pmis      = (brcond_taken_rt_i != bob_brdir_i);
                m_pchwe     = bob_chwe_i;
                m_cdir      = bob_chbrdir_i;
                m_lht_idx   = 10'((bob_brpc_i >> 2) & 64'h3FF);
                m_lht_wdata = 10'((int'(bob_bht_i) * 2 + int'(m_t)) % 1024);
                m_lpht_idx  = bob_bht_i;
                m_bhr       = bob_bhr_i;
                m_rbhr      = 12'((int'(bob_bhr_i) * 2 + int'(m_t)) % 4096);
                m_rpc       = m_t ? brcond_tgt_rt_i : bob_brpc_i + 64'd4;
                m_rras      = bob_rasptr_i;
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (m_pmis && m_mis < 64'hFFFF_FFFF) m_mis++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit rv, rb, rt, rr, rdir;
        logic [63:0] rpc, rtgt;

        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_lht_idx", lht_idx_o, 0);
        chk("rst_recov_pc", recov_pc_o, 0);
        step();

        // Correctly predicted taken branch.
        drive(0, 1, 1, 1, 64'h1000, 64'h5000, 1, 1, 1, 10'h155, 12'hABC, 4'h3);
        step();
        chk("tp1_lht_idx", lht_idx_o, 10'h000);
        chk("tp1_lht_wdata", lht_wdata_o, 10'h2AB);
        chk("tp1_gpht_idx", gpht_idx_o, 12'hABC);
        chk("tp1_recov_vld", recov_vld_o, 0);
        chk("tp1_br_cnt", br_cnt_o, 1);

        // Mispredicted taken branch, then retires offered during the drain window.
        drive(0, 1, 1, 1, 64'h3000, 64'h2000, 0, 0, 0, 10'h0, 12'h800, 4'h5);
        step();
        chk("tp2_recov_vld", recov_vld_o, 1);
        chk("tp2_flush", flush_o, 1);
        chk("tp2_recov_pc", recov_pc_o, 64'h2000);
        chk("tp2_recov_bhr", recov_bhr_o, 12'h001);
        chk("tp2_rasptr", recov_rasptr_o, 4'h5);
        idle_in();
        step();
        chk("tp2_busy0", busy_o, 1);
        drive(0, 1, 1, 1, 64'h4000, 64'h0, 1, 0, 0, 10'h1, 12'h1, 4'h1);
        step();
        chk("tp2_busy1", busy_o, 1);
        step();
        chk("tp2_busy_end", busy_o, 0);
        chk("tp2_br_cnt", br_cnt_o, 2);

        // Not-taken mispredict at the top of the address space wraps to 0.
        drive(0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1, 0, 0, 10'h3, 12'h7, 4'h2);
        step();
        chk("tp3_recov_pc", recov_pc_o, 64'h0);
        idle_in();
        repeat (3) step();

        // Back-to-back retires, then a mispredict with a younger retire right behind it.
        reset = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, i[0], 64'h100 + 64'(i * 4), 64'h900, i[0], 1, 1, 10'(i), 12'(i), 4'(i));
            step();
        end
        chk("tp4_br_cnt3", br_cnt_o, 3);
        drive(0, 1, 1, 1, 64'h200, 64'h700, 0, 0, 0, 10'h2, 12'h3, 4'h4);
        step();
        drive(0, 1, 1, 1, 64'h204, 64'h600, 1, 0, 0, 10'h2, 12'h3, 4'h4);
        step();
        chk("tp4_squash_we", lht_we_o, 0);
        idle_in();
        repeat (3) step();
        chk("tp4_br_cnt", br_cnt_o, 4);
        chk("tp4_mis_cnt", mis_cnt_o, 1);

        // Retire with an empty BOB.
        drive(0, 1, 0, 1, 64'h300, 64'h0, 1, 0, 0, 10'h0, 12'h0, 4'h0);
        step();
        chk("tp5_err", err_o, 1);
        idle_in();
        step();
        chk("tp5_err_sticky", err_o, 1);
        reset = 1'b1;
        step();
        chk("tp5_err_clr", err_o, 0);

        // Reset arriving with a mispredict accept aborts the recovery.
        drive(1, 1, 1, 1, 64'h500, 64'h900, 0, 1, 1, 10'h5, 12'h5, 4'h5);
        step();
        chk("tp6_recov_vld", recov_vld_o, 0);
        chk("tp6_busy", busy_o, 0);
        chk("tp6_br_cnt", br_cnt_o, 0);
        chk("tp6_mis_cnt", mis_cnt_o, 0);
        idle_in();
        step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rv   = ($urandom_range(0, 9) < 6);
            rb   = ($urandom_range(0, 9) < 8);
            rr   = ($urandom_range(0, 79) == 0);
            rt   = 1'($urandom);
            rdir = ($urandom_range(0, 3) == 0) ? ~rt : rt;
            rpc  = {$urandom, $urandom};
            rtgt = {$urandom, $urandom};
            drive(rr, rv, rb, rt, rpc, rtgt, rdir, 1'($urandom), 1'($urandom),
                  10'($urandom), 12'($urandom), 4'($urandom));
            step();
        end
        idle_in();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
